axis_packet_gate: RTL and testbench
===================================

// Module: axis_packet_gate
// PURPOSE
//  Ingress packet qualifier that drives the write side of the store-and-forward packet FIFO.
//  Accepts an AXI-Stream packet source with a per-beat error flag and enforces min/max length.
//  Forwards good packets beat-for-beat. Signals a bad packet by emitting one beat with
//  m_tdrop=1; the FIFO then rewinds to its last packet boundary. Keeps good/bad statistics.
// PARAMETERS
//  WIDTH   8     data width, bits
//  MINLEN  1     minimum legal packet length, beats (>=1)
//  MAXLEN  1024  maximum legal packet length, beats (MINLEN <= MAXLEN < 2**LBITS)
//  LBITS   11    width of the beat counter and len_o
//  CBITS   16    width of the statistics counters
// PORTS
//  clock      in   1      system clock, all logic on rising edge
//  reset_n    in   1      asynchronous, active-low reset
//  s_tvalid   in   1      source beat valid
//  s_tready   out  1      source beat accepted when s_tvalid && s_tready
//  s_tlast    in   1      last beat of packet
//  s_tuser    in   1      beat error flag (CRC/PHY error); any set beat poisons packet
//  s_tdata    in   WIDTH  source data
//  m_tvalid   out  1      FIFO-side beat valid
//  m_tready   in   1      FIFO ready
//  m_tlast    out  1      last beat of packet (commit)
//  m_tdrop    out  1      discard current packet; only ever asserted with m_tvalid
//  m_tdata    out  WIDTH  FIFO-side data
//  pkt_ok_o   out  1      1-cycle strobe: good packet's last beat transferred on m
//  pkt_bad_o  out  1      1-cycle strobe: drop beat transferred on m
//  len_o      out  LBITS  beat count of most recent good packet, updated with pkt_ok_o
//  ok_cnt_o   out  CBITS  good packets forwarded, wraps modulo 2**CBITS
//  bad_cnt_o  out  CBITS  packets dropped, wraps modulo 2**CBITS
// BEHAVIOUR
//  Reset (reset_n low, async): all outputs 0, including s_tready; state IDLE; beat counter 0.
//  Output stage: a single register, so latency is 1 cycle from s acceptance to m_tvalid.
//   - Register loads when s beat accepted in IDLE/PASS. It holds stable while m_tvalid && !m_tready.
//   - s_tready = !m_tvalid || m_tready in IDLE/PASS. In SKIP, s_tready = 1.
//   - Full throughput: one beat per cycle while m_tready=1.
//  Beat counter n: number of the accepted beat within the packet (1-based).
//   - Saturates at MAXLEN+1. Cleared when a packet ends (last accepted, or entry to IDLE).
//  States:
//   IDLE  no packet open. Any accepted beat opens a packet and is evaluated like PASS with n=1.
//   PASS  each accepted beat is evaluated in order:
//     bad = s_tuser || (n > MAXLEN) || (s_tlast && n < MINLEN).
//     - bad && s_tlast  : emit {drop=1, last=1}, go to IDLE.
//     - bad && !s_tlast : emit {drop=1, last=0}, go to SKIP.
//     - !bad && s_tlast : emit {drop=0, last=1}, go to IDLE.
//     - otherwise       : emit {drop=0, last=0}, stay in PASS.
//     - m_tdata always carries s_tdata; the FIFO ignores data on a drop beat.
//   SKIP  consume and discard beats, with no m output. The accepted s_tlast beat goes to IDLE.
//     s_tuser is ignored in SKIP.
//  Overlength: with MAXLEN=M, beats 1..M pass. Beat M+1 is emitted as the drop beat, then SKIP.
//  At most one drop beat per packet. m_tlast && !m_tdrop marks the only commit.
//  Strobes and counters update on the m transfer cycle (m_tvalid && m_tready), not on s acceptance.
//  Simultaneous m transfer and s acceptance in the same cycle: both take effect, with no bubble.
//  Reset mid-packet: partial packet abandoned. The FIFO's own reset clears its uncommitted data.
//  The first packet after reset starts at n=1.
// TESTING
//  1 Good packet: MINLEN=1, MAXLEN=8; 4 beats 0x11..0x14, m_tready=1
//    -> m beats 0x11..0x14 one cycle later, last on 0x14, pkt_ok_o=1, len_o=4, ok_cnt_o=1.
//  2 Error: 5-beat packet, s_tuser=1 on beat 2
//    -> beat 1 passes, beat 2 out with m_tdrop=1 and m_tlast=0, beats 3-5 accepted with no m output.
//    -> pkt_bad_o once, bad_cnt_o=1, next packet forwarded intact.
//  3 Overlength: MAXLEN=8; 10-beat packet
//    -> beats 1-8 pass, beat 9 m_tdrop=1, beat 10 swallowed (s_tready=1), ok_cnt_o unchanged.
//  4 Undersize/last-beat error: MINLEN=2; 1-beat packet -> single beat with m_tdrop=1 and m_tlast=1.
//    3-beat packet with s_tuser on last beat -> same response; state returns to IDLE.
//  5 Back-pressure: 50 random packets, m_tready random 50%, s_tvalid random
//    -> m stream equals scoreboard, with no loss or duplicates, and m_tdata is stable while stalled.
//    -> 1 beat/cycle when m_tready=1.
//  6 Reset mid-packet: assert reset_n low on beat 3 of 6
//    -> all outputs 0 asynchronously; after release, a new 2-beat packet gives len_o=2.
//    -> counters restart at 0.

Source files
------------

// File: rtl/axis_packet_gate.sv
// Qualifies AXI-Stream packets (error flag, min/max length) ahead of the store-and-forward FIFO.
// One registered output stage gives 1-cycle latency; the source stalls only while that stage is full and stalled.
module axis_packet_gate #(
    parameter int WIDTH  = 8,
    parameter int MINLEN = 1,
    parameter int MAXLEN = 1024,
    parameter int LBITS  = 11,
    parameter int CBITS  = 16
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             s_tvalid,
    output logic             s_tready,
    input  logic             s_tlast,
    input  logic             s_tuser,
    input  logic [WIDTH-1:0] s_tdata,
    output logic             m_tvalid,
    input  logic             m_tready,
    output logic             m_tlast,
    output logic             m_tdrop,
    output logic [WIDTH-1:0] m_tdata,
    output logic             pkt_ok_o,
    output logic             pkt_bad_o,
    output logic [LBITS-1:0] len_o,
    output logic [CBITS-1:0] ok_cnt_o,
    output logic [CBITS-1:0] bad_cnt_o
);

    // One extra bit so the saturation value MAXLEN+1 always fits.
    localparam int NW = LBITS + 1;
    localparam logic [NW-1:0] MAX_N = NW'(MAXLEN);
    localparam logic [NW-1:0] SAT_N = NW'(MAXLEN + 1);
    localparam logic [NW-1:0] MIN_N = NW'(MINLEN);

    typedef enum logic [1:0] {IDLE, PASS, SKIP} state_t;

    state_t           state_q;
    logic             run_q;
    logic [NW-1:0]    n_q;
    logic [NW-1:0]    n_d;
    logic             bad_d;
    logic             m_vld_q;
    logic             m_last_q;
    logic             m_drop_q;
    logic [WIDTH-1:0] m_dat_q;
    logic [LBITS-1:0] m_len_q;
    logic             ok_q;
    logic             bad_q;
    logic [LBITS-1:0] len_q;
    logic [CBITS-1:0] ok_cnt_q;
    logic [CBITS-1:0] bad_cnt_q;
    logic             s_acc;
    logic             m_xfer;

    // run_q keeps s_tready low while reset is held and for the first edge after release.
    assign s_tready = run_q && ((state_q == SKIP) || !m_vld_q || m_tready);
    assign s_acc    = s_tvalid && s_tready;
    assign m_xfer   = m_vld_q && m_tready;

    always_comb begin
        n_d   = (n_q == SAT_N) ? SAT_N : n_q + NW'(1);
        bad_d = s_tuser || (n_d > MAX_N) || (s_tlast && (n_d < MIN_N));
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            run_q     <= 1'b0;
            n_q       <= '0;
            m_vld_q   <= 1'b0;
            m_last_q  <= 1'b0;
            m_drop_q  <= 1'b0;
            m_dat_q   <= '0;
            m_len_q   <= '0;
            ok_q      <= 1'b0;
            bad_q     <= 1'b0;
            len_q     <= '0;
            ok_cnt_q  <= '0;
            bad_cnt_q <= '0;
        end else begin
            run_q <= 1'b1;
            ok_q  <= 1'b0;
            bad_q <= 1'b0;
            if (m_xfer) begin
                m_vld_q <= 1'b0;
                if (m_drop_q) begin
                    bad_q     <= 1'b1;
                    bad_cnt_q <= bad_cnt_q + CBITS'(1);
                end else if (m_last_q) begin
                    ok_q     <= 1'b1;
                    ok_cnt_q <= ok_cnt_q + CBITS'(1);
                    len_q    <= m_len_q;
                end
            end
            if (s_acc) begin
                n_q <= s_tlast ? '0 : n_d;
                if (state_q == SKIP) begin
                    if (s_tlast) state_q <= IDLE;
                end else begin
                    // A load here overrides the clear above, so a same-cycle drain and refill has no bubble.
                    m_vld_q  <= 1'b1;
                    m_dat_q  <= s_tdata;
                    m_last_q <= s_tlast;
                    m_drop_q <= bad_d;
                    m_len_q  <= n_d[LBITS-1:0];
                    state_q  <= s_tlast ? IDLE : (bad_d ? SKIP : PASS);
                end
            end
        end
    end

    assign m_tvalid  = m_vld_q;
    assign m_tlast   = m_last_q;
    assign m_tdrop   = m_drop_q;
    assign m_tdata   = m_dat_q;
    assign pkt_ok_o  = ok_q;
    assign pkt_bad_o = bad_q;
    assign len_o     = len_q;
    assign ok_cnt_o  = ok_cnt_q;
    assign bad_cnt_o = bad_cnt_q;

endmodule

// File: tb/tb_axis_packet_gate.sv
// Bench for axis_packet_gate with MINLEN=2, MAXLEN=8; a per-packet reference model predicts the m-side stream.
module tb_axis_packet_gate;

    localparam int MINLEN = 2;
    localparam int MAXLEN = 8;

    logic        clock;
    logic        reset_n;
    logic        s_tvalid, s_tready, s_tlast, s_tuser;
    logic [7:0]  s_tdata;
    logic        m_tvalid, m_tready, m_tlast, m_tdrop;
    logic [7:0]  m_tdata;
    logic        pkt_ok_o, pkt_bad_o;
    logic [10:0] len_o;
    logic [15:0] ok_cnt_o, bad_cnt_o;

    axis_packet_gate #(.WIDTH(8), .MINLEN(MINLEN), .MAXLEN(MAXLEN), .LBITS(11), .CBITS(16)) dut (
        .clock(clock), .reset_n(reset_n),
        .s_tvalid(s_tvalid), .s_tready(s_tready), .s_tlast(s_tlast), .s_tuser(s_tuser), .s_tdata(s_tdata),
        .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tlast(m_tlast), .m_tdrop(m_tdrop), .m_tdata(m_tdata),
        .pkt_ok_o(pkt_ok_o), .pkt_bad_o(pkt_bad_o), .len_o(len_o), .ok_cnt_o(ok_cnt_o), .bad_cnt_o(bad_cnt_o)
    );

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    bit rand_rdy = 0;
    int exp_ok = 0;
    int exp_bad = 0;
    int stall_err = 0;
    bit stall_prev = 0;
    logic [9:0] stall_val;
    logic [7:0] dbuf [1:20];

    logic [9:0] exp_q [$];    // {data, last, drop}
    int         exp_len_q [$];
    logic [9:0] obs_b [$];
    int         obs_c [$];
    int         acc_c [$];
    bit         str_ok [$];
    int         str_len [$];
    int         str_c [$];

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    always @(posedge clock) cyc <= cyc + 1;

    initial begin
        m_tready = 1'b1;
        forever begin
            @(posedge clock);
            #1;
            m_tready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // Records m transfers (stamped with the edge they happen on), strobes, and stall violations.
    always @(negedge clock) begin
        if (!reset_n) begin
            stall_prev = 0;
        end else begin
            if (m_tvalid && m_tready) begin
                obs_b.push_back({m_tdata, m_tlast, m_tdrop});
                obs_c.push_back(cyc + 1);
            end
            if (pkt_ok_o || pkt_bad_o) begin
                str_ok.push_back(pkt_ok_o);
                str_len.push_back(int'(len_o));
                str_c.push_back(cyc);
            end
            if (stall_prev && !(m_tvalid && ({m_tdata, m_tlast, m_tdrop} == stall_val))) stall_err++;
            stall_prev = m_tvalid && !m_tready;
            stall_val  = {m_tdata, m_tlast, m_tdrop};
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    task automatic clear_q();
        exp_q.delete(); exp_len_q.delete(); obs_b.delete(); obs_c.delete();
        acc_c.delete(); str_ok.delete(); str_len.delete(); str_c.delete();
    endtask

    // Reference: walk beats in order; the first bad beat becomes the drop beat and ends the m output.
    task automatic model_pkt(input int len, input int err_beat);
        for (int i = 1; i <= len; i++) begin
            bit last = (i == len);
            bit bad = (i == err_beat) || (i > MAXLEN) || (last && i < MINLEN);
            exp_q.push_back({dbuf[i], last, bad});
            if (bad) begin
                exp_bad++;
                break;
            end
            if (last) begin
                exp_ok++;
                exp_len_q.push_back(len);
            end
        end
    endtask

    // Call at posedge+1. Fills dbuf, updates the model, then drives the packet with handshakes.
    task automatic send_pkt(input int len, input int err_beat, input logic [7:0] base, input bit rnd);
        for (int i = 1; i <= len; i++) dbuf[i] = rnd ? 8'($urandom) : base + 8'(i - 1);
        model_pkt(len, err_beat);
        for (int i = 1; i <= len; i++) begin
            int to = 0;
            if (rnd && $urandom_range(0, 3) == 0) begin
                s_tvalid = 1'b0;
                @(posedge clock);
                #1;
            end
            s_tvalid = 1'b1;
            s_tdata  = dbuf[i];
            s_tlast  = (i == len);
            s_tuser  = (i == err_beat);
            forever begin
                @(negedge clock);
                if (s_tready) break;
                to++;
                if (to > 200) break;
            end
            acc_c.push_back(cyc + 1);
            @(posedge clock);
            #1;
        end
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
        s_tuser  = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (obs_b.size() < exp_q.size() && n < 400) begin
            @(posedge clock);
            n++;
        end
        repeat (3) @(posedge clock);
        @(negedge clock);
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        s_tvalid = 1'b0; s_tlast = 1'b0; s_tuser = 1'b0; s_tdata = 8'h00;
        #3;
        checks++;
        if ({s_tready, m_tvalid, m_tlast, m_tdrop, m_tdata, pkt_ok_o, pkt_bad_o, len_o, ok_cnt_o, bad_cnt_o} !== '0) begin
            failures++;
            $display("FAIL reset_outputs s_tready=%b m_tvalid=%b ok_cnt=%0d bad_cnt=%0d exp all 0",
                     s_tready, m_tvalid, ok_cnt_o, bad_cnt_o);
        end
        #19 reset_n = 1'b1;
        @(negedge clock);
        checks++;
        if ({s_tready, m_tvalid} !== 2'b10) begin
            failures++;
            $display("FAIL reset_release s_tready/m_tvalid got=%b%b exp=10", s_tready, m_tvalid);
        end
    endtask

    task automatic test_good();
        logic [9:0] got;
        clear_q();
        @(posedge clock); #1;
        send_pkt(4, 0, 8'h11, 0);
        drain();
        checks++;
        if (obs_b.size() !== exp_q.size()) begin
            failures++;
            $display("FAIL good_count got=%0d exp=%0d", obs_b.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size(); i++) begin
            got = (i < obs_b.size()) ? obs_b[i] : 10'bx;
            checks++;
            if (got !== exp_q[i]) begin
                failures++;
                $display("FAIL good_beat%0d got=%h exp=%h", i, got, exp_q[i]);
            end
            checks++;
            if (i >= obs_c.size() || obs_c[i] !== acc_c[i] + 1) begin
                failures++;
                $display("FAIL good_latency%0d got=%0d exp=%0d", i, (i < obs_c.size()) ? obs_c[i] : -1, acc_c[i] + 1);
            end
        end
        checks++;
        if (str_ok.size() !== 1 || str_ok[0] !== 1'b1 || str_len[0] !== 4 || str_c[0] !== obs_c[3]) begin
            failures++;
            $display("FAIL good_strobe got n=%0d len=%0d exp n=1 len=4", str_ok.size(), len_o);
        end
        checks++;
        if (ok_cnt_o !== 16'(exp_ok) || bad_cnt_o !== 16'(exp_bad)) begin
            failures++;
            $display("FAIL good_counters got ok=%0d bad=%0d exp ok=%0d bad=%0d", ok_cnt_o, bad_cnt_o, exp_ok, exp_bad);
        end
    endtask

    task automatic test_error();
        logic [9:0] got;
        int nbad = 0;
        clear_q();
        @(posedge clock); #1;
        send_pkt(5, 2, 8'h21, 0);
        send_pkt(3, 0, 8'h31, 0);
        drain();
        checks++;
        if (obs_b.size() !== exp_q.size()) begin
            failures++;
            $display("FAIL error_count got=%0d exp=%0d", obs_b.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size(); i++) begin
            got = (i < obs_b.size()) ? obs_b[i] : 10'bx;
            checks++;
            if (got !== exp_q[i]) begin
                failures++;
                $display("FAIL error_beat%0d got=%h exp=%h", i, got, exp_q[i]);
            end
        end
        foreach (str_ok[i]) if (!str_ok[i]) nbad++;
        checks++;
        if (nbad !== 1 || bad_cnt_o !== 16'(exp_bad) || ok_cnt_o !== 16'(exp_ok)) begin
            failures++;
            $display("FAIL error_counters got bad_strobes=%0d bad=%0d ok=%0d exp 1 %0d %0d",
                     nbad, bad_cnt_o, ok_cnt_o, exp_bad, exp_ok);
        end
    endtask

    task automatic test_overlength();
        logic [9:0] got;
        clear_q();
        @(posedge clock); #1;
        send_pkt(10, 0, 8'h80, 0);
        drain();
        checks++;
        if (obs_b.size() !== 9 || exp_q.size() !== 9) begin
            failures++;
            $display("FAIL overlen_count got=%0d exp=9", obs_b.size());
        end
        for (int i = 0; i < exp_q.size(); i++) begin
            got = (i < obs_b.size()) ? obs_b[i] : 10'bx;
            checks++;
            if (got !== exp_q[i]) begin
                failures++;
                $display("FAIL overlen_beat%0d got=%h exp=%h", i, got, exp_q[i]);
            end
        end
        checks++;
        if (ok_cnt_o !== 16'(exp_ok) || bad_cnt_o !== 16'(exp_bad)) begin
            failures++;
            $display("FAIL overlen_counters got ok=%0d bad=%0d exp ok=%0d bad=%0d", ok_cnt_o, bad_cnt_o, exp_ok, exp_bad);
        end
    endtask

    task automatic test_undersize();
        logic [9:0] got;
        clear_q();
        @(posedge clock); #1;
        send_pkt(1, 0, 8'h41, 0);
        send_pkt(3, 3, 8'h51, 0);
        send_pkt(2, 0, 8'h61, 0);
        drain();
        checks++;
        if (obs_b.size() !== exp_q.size()) begin
            failures++;
            $display("FAIL under_count got=%0d exp=%0d", obs_b.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size(); i++) begin
            got = (i < obs_b.size()) ? obs_b[i] : 10'bx;
            checks++;
            if (got !== exp_q[i]) begin
                failures++;
                $display("FAIL under_beat%0d got=%h exp=%h", i, got, exp_q[i]);
            end
        end
        checks++;
        if (len_o !== 11'd2 || ok_cnt_o !== 16'(exp_ok) || bad_cnt_o !== 16'(exp_bad)) begin
            failures++;
            $display("FAIL under_counters got len=%0d ok=%0d bad=%0d exp len=2 ok=%0d bad=%0d",
                     len_o, ok_cnt_o, bad_cnt_o, exp_ok, exp_bad);
        end
    endtask

    task automatic test_back_to_back();
        clear_q();
        @(posedge clock); #1;
        send_pkt(3, 0, 8'h90, 0);
        send_pkt(3, 0, 8'hA0, 0);
        drain();
        checks++;
        if (obs_c.size() !== 6) begin
            failures++;
            $display("FAIL b2b_count got=%0d exp=6", obs_c.size());
        end
        for (int i = 1; i < obs_c.size(); i++) begin
            checks++;
            if (obs_c[i] !== obs_c[0] + i || obs_b[i] !== exp_q[i]) begin
                failures++;
                $display("FAIL b2b_beat%0d got cyc=%0d dat=%h exp cyc=%0d dat=%h", i, obs_c[i], obs_b[i], obs_c[0] + i, exp_q[i]);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [9:0] got;
        int k = 0;
        clear_q();
        stall_err = 0;
        rand_rdy = 1;
        @(posedge clock); #1;
        for (int p = 0; p < 50; p++) begin
            int len = $urandom_range(1, 12);
            int err = ($urandom_range(0, 3) == 0) ? $urandom_range(1, len) : 0;
            send_pkt(len, err, 8'h00, 1);
        end
        rand_rdy = 0;
        drain();
        checks++;
        if (obs_b.size() !== exp_q.size()) begin
            failures++;
            $display("FAIL bp_count got=%0d exp=%0d", obs_b.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size(); i++) begin
            got = (i < obs_b.size()) ? obs_b[i] : 10'bx;
            checks++;
            if (got !== exp_q[i]) begin
                failures++;
                $display("FAIL bp_beat%0d got=%h exp=%h", i, got, exp_q[i]);
            end
        end
        checks++;
        if (stall_err !== 0) begin
            failures++;
            $display("FAIL bp_stall_stable got=%0d violations exp=0", stall_err);
        end
        foreach (str_ok[i]) begin
            if (str_ok[i]) begin
                checks++;
                if (k >= exp_len_q.size() || str_len[i] !== exp_len_q[k]) begin
                    failures++;
                    $display("FAIL bp_len%0d got=%0d exp=%0d", k, str_len[i], (k < exp_len_q.size()) ? exp_len_q[k] : -1);
                end
                k++;
            end
        end
        checks++;
        if (k !== exp_len_q.size() || ok_cnt_o !== 16'(exp_ok) || bad_cnt_o !== 16'(exp_bad)) begin
            failures++;
            $display("FAIL bp_counters got strobes=%0d ok=%0d bad=%0d exp strobes=%0d ok=%0d bad=%0d",
                     k, ok_cnt_o, bad_cnt_o, exp_len_q.size(), exp_ok, exp_bad);
        end
    endtask

    task automatic test_reset_mid();
        clear_q();
        @(posedge clock); #1;
        for (int i = 1; i <= 2; i++) begin
            int to = 0;
            s_tvalid = 1'b1; s_tdata = 8'hC0 + 8'(i); s_tlast = 1'b0; s_tuser = 1'b0;
            forever begin
                @(negedge clock);
                if (s_tready || to > 200) break;
                to++;
            end
            @(posedge clock);
            #1;
        end
        s_tdata = 8'hC3;
        #2 reset_n = 1'b0;
        #1;
        checks++;
        if ({s_tready, m_tvalid, m_tlast, m_tdrop, m_tdata, pkt_ok_o, pkt_bad_o, len_o, ok_cnt_o, bad_cnt_o} !== '0) begin
            failures++;
            $display("FAIL midreset_outputs m_tvalid=%b m_tdata=%h ok_cnt=%0d len=%0d exp all 0",
                     m_tvalid, m_tdata, ok_cnt_o, len_o);
        end
        s_tvalid = 1'b0;
        exp_ok = 0;
        exp_bad = 0;
        @(negedge clock);
        reset_n = 1'b1;
        clear_q();
        @(posedge clock); #1;
        send_pkt(2, 0, 8'hD0, 0);
        drain();
        checks++;
        if (len_o !== 11'd2 || ok_cnt_o !== 16'd1 || bad_cnt_o !== 16'd0) begin
            failures++;
            $display("FAIL midreset_after got len=%0d ok=%0d bad=%0d exp len=2 ok=1 bad=0", len_o, ok_cnt_o, bad_cnt_o);
        end
        checks++;
        if (obs_b.size() !== 2 || obs_b[0] !== exp_q[0] || obs_b[1] !== exp_q[1]) begin
            failures++;
            $display("FAIL midreset_stream got n=%0d exp n=2", obs_b.size());
        end
    endtask

    initial begin
        test_reset();
        test_good();
        test_error();
        test_overlength();
        test_undersize();
        test_back_to_back();
        test_backpressure();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
